serial_twos_neg: RTL
====================

# serial_twos_neg

Parametrised bit-serial two's-complement negator. Accepts WIDTH-bit words LSB-first, one bit per accepted cycle, framed by a start-of-word strobe. It emits the negated word, or passes it through, per word. Flags overflow when the most negative value is negated. It is the framed, word-aware, mode-selectable successor to the single-stream serial inverter. It sits between serial sources and downstream serial arithmetic.

## Interface
- WIDTH, 8, word length in bits (≥2)
- CNT_W, $clog2(WIDTH), bit-counter width (derived, do not override)

- t_clock  in  1  clock, rising edge
- r_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_bit/in_sof valid this cycle
- in_sof  in  1  first (LSB) bit of a word; qualified by in_valid
- in_bit  in  1  serial data, LSB first
- neg  in  1  1 = negate word, 0 = pass through; sampled only with in_sof & in_valid
- out_valid  out  1  out_bit valid
- out_bit  out  1  result bit, LSB first
- out_eof  out  1  marks MSB (last) result bit of a word
- ovf  out  1  pulse with out_eof: negation of 100…0 overflowed
- sof_err  out  1  one-cycle pulse: word aborted by premature in_sof

## Operation
- States: IDLE (waiting for sof), RUN (word in progress).
- Registers: cnt[CNT_W-1:0], seen_one (any 1 among prior bits of the word), mode (latched neg).
- Accepted bit = in_valid=1 in RUN, or in_valid & in_sof in any state.
- In IDLE, in_valid without in_sof: bit dropped, no output, no error.
- On in_sof & in_valid: cnt←1, mode←neg, the bit is processed as bit 0 with seen_one treated as 0, seen_one←in_bit, state←RUN (WIDTH=… see boundary below).
- Processing a bit b: result = mode ? (b ^ seen_one) : b; seen_one←seen_one | b; cnt←cnt+1.
- The bit with cnt==WIDTH-1 is the MSB. Output out_eof=1 with it, then state←IDLE, cnt←0.
- ovf=1 with out_eof iff mode=1, MSB b=1, and seen_one=0 before the MSB (input 100…0). The output word is then 100…0 unchanged.
- Input 0 negated gives 0, with ovf=0.
- in_sof in RUN before the MSB: current word abandoned (no out_eof for it), sof_err pulses, new word starts with this bit.
- in_sof coincident with an MSB is not legal framing; treated as an abort (sof_err=1, no out_eof for the old word).
- in_valid=0 cycles (gaps) anywhere: state, cnt, seen_one held; out_valid=0.

## Timing
- All outputs registered; latency exactly 1 cycle from accepted bit to out_valid/out_bit.
- out_valid=1 exactly one cycle per accepted bit. out_eof and ovf are valid only while out_valid=1.
- Back-to-back words: a new sof may be accepted the cycle after the MSB, with no bubble required.
- Reset (r_n=0, async, any time including mid-word): state IDLE, cnt=0, seen_one=0, mode=0. All outputs 0 (out_valid, out_bit, out_eof, ovf, sof_err; par_* if present). The partial word is discarded.
- First possible output: 1 cycle after the first accepted sof following reset release.

## Configuration
- TWOS_PAR_OUT_EN defined: adds ports par_out (out, WIDTH, full result word) and par_valid (out, 1).
  - par_valid pulses with out_eof. par_out holds the assembled result until the next par_valid or reset.
  - Reset value of par_out is 0. An aborted word never updates par_out.
- Not defined: ports and the shift register are absent. Serial behaviour is identical.

## Test plan
- WIDTH=8, neg=1, word 0x05 (in bits 1,0,1,0,0,0,0,0) -> out bits 1,1,0,1,1,1,1,1 (0xFB), out_eof on 8th, ovf=0.
- neg=1, word 0x80 -> out 0x80, ovf=1 with out_eof. neg=1, word 0x00 -> out 0x00, ovf=0. neg=0, word 0x3C -> out 0x3C unchanged.
- neg=1, word 0x01 with in_valid low 3 cycles after bit 2 -> out 0xFF; out_valid low during gap; out_eof still on the 8th valid output.
- Word 0x05 aborted by in_sof at bit 4, then new word 0x02 with neg=1 -> sof_err pulse, no out_eof for first word, second yields 0xFE.
- r_n asserted mid-word then released, fresh sof with 0x7F, neg=1 -> all outputs 0 during reset, then 0x81, ovf=0. With TWOS_PAR_OUT_EN: par_out=0x81 with par_valid.

Source files
------------

// File: rtl/serial_twos_neg.sv
// serial_twos_neg: framed bit-serial two's-complement negator / pass-through, LSB first.
// Define TWOS_PAR_OUT_EN to add the par_out/par_valid parallel result port.
module serial_twos_neg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic t_clock,
    input  logic r_n,
    input  logic in_valid,
    input  logic in_sof,
    input  logic in_bit,
    input  logic neg,
    output logic out_valid,
    output logic out_bit,
    output logic out_eof,
    output logic ovf,
`ifdef TWOS_PAR_OUT_EN
    output logic sof_err,
    output logic [WIDTH-1:0] par_out,
    output logic par_valid
`else
    output logic sof_err
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cur_cnt;
    logic             seen_q, seen_d, mode_q, mode_d;
    logic             sof, acc, cur_seen, cur_mode, msb, res;

    // A sof restarts the word in any state, so its bit sees a fresh context.
    always_comb begin
        sof      = in_valid & in_sof;
        acc      = sof | (in_valid & (state_q == RUN));
        cur_seen = sof ? 1'b0 : seen_q;
        cur_mode = sof ? neg : mode_q;
        cur_cnt  = sof ? '0 : cnt_q;
        msb      = cur_cnt == CNT_W'(WIDTH - 1);
        res      = cur_mode ? (in_bit ^ cur_seen) : in_bit;
        state_d  = acc ? (msb ? IDLE : RUN) : state_q;
        cnt_d    = acc ? (msb ? '0 : cur_cnt + CNT_W'(1)) : cnt_q;
        seen_d   = acc ? (~msb & (cur_seen | in_bit)) : seen_q;
        mode_d   = acc ? cur_mode : mode_q;
    end

    always_ff @(posedge t_clock or negedge r_n) begin
        if (!r_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seen_q    <= 1'b0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_eof   <= 1'b0;
            ovf       <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
            mode_q    <= mode_d;
            out_valid <= acc;
            out_bit   <= res;
            out_eof   <= acc & msb;
            ovf       <= acc & msb & cur_mode & in_bit & ~cur_seen;
            sof_err   <= sof & (state_q == RUN);
        end
    end

`ifdef TWOS_PAR_OUT_EN
    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-1:0] word;

    always_comb word = {res, sr_q};

    // par_out only loads on a completed word, so aborted words never reach it.
    always_ff @(posedge t_clock or negedge r_n) begin
        if (!r_n) begin
            sr_q      <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
        end else begin
            par_valid <= acc & msb;
            if (acc) sr_q <= word[WIDTH-1:1];
            if (acc & msb) par_out <= word;
        end
    end
`endif
endmodule
